// File: rtl/acq_sample_if.sv
// ADC sample bus from the rate divider: one strobe plus both channel samples.
interface acq_sample_if #(
    parameter int DATA_W = 8
);
    logic              sample_en;
    logic [DATA_W-1:0] adc1_d;
    logic [DATA_W-1:0] adc2_d;

    modport master (output sample_en, adc1_d, adc2_d);
    modport slave  (input  sample_en, adc1_d, adc2_d);
endinterface

// File: rtl/acq_controller.sv
// Scope acquisition sequencer: pre-trigger fill, trigger search, post-trigger
// fill into the circular sample buffer, then a ready flag for the MCU.
module acq_controller #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8,
    parameter int AUTO_TO = 4096
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_go,
    acq_sample_if.slave       i_smp,
    input  logic              i_trig_chan,
    input  logic              i_trig_edge,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic              i_trig_mode,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [ADDR_W-1:0] o_trig_addr,
    output logic [ADDR_W-1:0] o_start_addr,
    output logic [1:0]        o_ready,
    output logic [2:0]        o_state
);
    localparam int HALF_I = 2 ** (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] HALF      = ADDR_W'(HALF_I);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(HALF_I - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(HALF_I - 2);
    localparam logic [15:0]       TO_LAST   = 16'(AUTO_TO - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_go_d;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_start_addr;
    logic [1:0]        r_ready;
    logic [ADDR_W-1:0] r_cnt;
    logic [15:0]       r_to;
    logic              r_auto;
    logic [DATA_W-1:0] r_prev1;
    logic [DATA_W-1:0] r_prev2;

    logic              w_wr_en;
    logic              w_go_rise;
    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] w_prev;
    logic              w_rise;
    logic              w_fall;
    logic              w_hit;

    assign w_wr_en   = i_smp.sample_en &
                       ((r_state == PRE) | (r_state == ARMED) | (r_state == POST));
    assign w_go_rise = i_go & ~r_go_d;

    // Both channels' last samples are kept so a live channel switch still
    // compares against the right history.
    assign w_cur  = i_trig_chan ? i_smp.adc2_d : i_smp.adc1_d;
    assign w_prev = i_trig_chan ? r_prev2 : r_prev1;
    assign w_rise = (w_prev <= i_trig_level) && (w_cur > i_trig_level);
    assign w_fall = (w_prev > i_trig_level) && (w_cur <= i_trig_level);
    assign w_hit  = i_trig_edge ? w_fall : w_rise;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_go_d       <= 1'b0;
            r_wr_addr    <= '0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
            r_ready      <= 2'b00;
            r_cnt        <= '0;
            r_to         <= '0;
            r_auto       <= 1'b0;
            r_prev1      <= '0;
            r_prev2      <= '0;
        end else begin
            r_go_d <= i_go;
            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + 1'b1;
                r_prev1   <= i_smp.adc1_d;
                r_prev2   <= i_smp.adc2_d;
            end
            case (r_state)
                IDLE: begin
                    if (w_go_rise) begin
                        r_state <= PRE;
                        r_cnt   <= '0;
                        r_ready <= 2'b00;
                    end
                end
                PRE: begin
                    if (!i_go) begin
                        r_state <= IDLE;
                        r_ready <= 2'b00;
                    end else if (w_wr_en) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == PRE_LAST) begin
                            r_state <= ARMED;
                            r_to    <= '0;
                        end
                    end
                end
                ARMED: begin
                    if (!i_go) begin
                        r_state <= IDLE;
                        r_ready <= 2'b00;
                    end else if (w_wr_en) begin
                        if (w_hit) begin
                            r_trig_addr <= r_wr_addr;
                            r_auto      <= 1'b0;
                            r_state     <= POST;
                            r_cnt       <= '0;
                        end else begin
                            r_to <= r_to + 1'b1;
                            if (!i_trig_mode && r_to == TO_LAST) begin
                                r_trig_addr <= r_wr_addr;
                                r_auto      <= 1'b1;
                                r_state     <= POST;
                                r_cnt       <= '0;
                            end
                        end
                    end
                end
                POST: begin
                    if (!i_go) begin
                        r_state <= IDLE;
                        r_ready <= 2'b00;
                    end else if (w_wr_en) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == POST_LAST) begin
                            r_state      <= DONE;
                            r_start_addr <= r_trig_addr + HALF;
                            r_ready      <= {r_auto, 1'b1};
                        end
                    end
                end
                DONE: begin
                    if (!i_go) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_wr_en      = w_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_trig_addr  = r_trig_addr;
    assign o_start_addr = r_start_addr;
    assign o_ready      = r_ready;
    assign o_state      = r_state;
endmodule

// File: tb/tb_acq_controller.sv
// Directed bench for acq_controller with a 16-entry buffer and AUTO_TO=20.
module tb_acq_controller;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int AUTO_TO = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              go = 1'b0;
    logic              tchan = 1'b0;
    logic              tedge = 1'b0;
    logic [DATA_W-1:0] tlevel = '0;
    logic              tmode = 1'b1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] start_addr;
    logic [1:0]        ready;
    logic [2:0]        state;

    int n_tot = 0;
    int n_pass = 0;
    int n_fail = 0;

    acq_sample_if #(.DATA_W(DATA_W)) smp ();

    acq_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_TO(AUTO_TO)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_go(go), .i_smp(smp),
        .i_trig_chan(tchan), .i_trig_edge(tedge),
        .i_trig_level(tlevel), .i_trig_mode(tmode),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_trig_addr(trig_addr),
        .o_start_addr(start_addr), .o_ready(ready), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic samp(input int a1, input int a2);
        smp.sample_en = 1'b1;
        smp.adc1_d = DATA_W'(a1);
        smp.adc2_d = DATA_W'(a2);
        tick();
        smp.sample_en = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Ramp on ch1, rising through 10, normal mode; gap idle cycles per sample.
    task automatic run_ramp(input int gap);
        tchan = 1'b0; tedge = 1'b0; tlevel = 8'd10; tmode = 1'b1;
        go = 1'b1;
        tick();
        chk("ramp_pre_state", 32'(state), 1);
        for (int v = 0; v < 19; v++) begin
            smp.sample_en = 1'b1;
            smp.adc1_d = DATA_W'(v);
            smp.adc2_d = '0;
            #1;
            chk("ramp_wr_en", 32'(wr_en), 1);
            chk("ramp_wr_addr", 32'(wr_addr), 32'(v % 16));
            tick();
            smp.sample_en = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            if (v == 7) chk("ramp_armed", 32'(state), 2);
            if (v == 10) chk("ramp_no_trig_at_10", 32'(state), 2);
            if (v == 11) begin
                chk("ramp_post", 32'(state), 3);
                chk("ramp_trig_addr", 32'(trig_addr), 11);
            end
        end
        chk("ramp_done", 32'(state), 4);
        chk("ramp_ready", 32'(ready), 1);
        chk("ramp_trig_final", 32'(trig_addr), 11);
        chk("ramp_start", 32'(start_addr), 3);
        chk("ramp_wr_addr_end", 32'(wr_addr), 3);
    endtask

    initial begin
        smp.sample_en = 1'b0;
        smp.adc1_d = '0;
        smp.adc2_d = '0;

        // Reset state
        do_reset();
        chk("rst_state", 32'(state), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);

        // 1: ramp trigger with continuous samples
        run_ramp(0);
        samp(19, 0);
        chk("done_ignores_wr", 32'(wr_addr), 3);
        chk("done_holds", 32'(state), 4);
        go = 1'b0;
        tick();
        chk("done_to_idle", 32'(state), 0);
        chk("idle_ready_held", 32'(ready), 1);

        // 2: auto-forced trigger, starting at wr_addr 3
        tmode = 1'b0;
        go = 1'b1;
        tick();
        chk("go_clears_ready", 32'(ready), 0);
        for (int i = 0; i < 8; i++) samp(5, 0);
        chk("auto_armed", 32'(state), 2);
        chk("auto_armed_addr", 32'(wr_addr), 11);
        for (int i = 0; i < 19; i++) samp(5, 0);
        chk("auto_not_yet", 32'(state), 2);
        samp(5, 0);
        chk("auto_forced", 32'(state), 3);
        chk("auto_trig_addr", 32'(trig_addr), 14);
        for (int i = 0; i < 6; i++) samp(5, 0);
        chk("auto_post_last", 32'(state), 3);
        samp(5, 0);
        chk("auto_done", 32'(state), 4);
        chk("auto_ready", 32'(ready), 3);
        chk("auto_start", 32'(start_addr), 6);
        chk("auto_wr_addr", 32'(wr_addr), 6);
        go = 1'b0;
        tick();

        // 3: normal mode never times out
        do_reset();
        tmode = 1'b1;
        go = 1'b1;
        tick();
        for (int i = 0; i < 208; i++) samp(5, 0);
        chk("norm_still_armed", 32'(state), 2);
        chk("norm_ready", 32'(ready), 0);
        chk("norm_wr_addr", 32'(wr_addr), 0);

        // 5: abort with a matching sample in the same cycle
        go = 1'b0;
        samp(11, 0);
        chk("abort_idle", 32'(state), 0);
        chk("abort_ready", 32'(ready), 0);
        chk("abort_wr_addr", 32'(wr_addr), 1);
        for (int i = 0; i < 3; i++) samp(12, 0);
        chk("idle_no_writes", 32'(wr_addr), 1);
        go = 1'b1;
        tick();
        chk("restart_pre", 32'(state), 1);
        for (int i = 0; i < 8; i++) samp(0, 0);
        chk("restart_armed", 32'(state), 2);
        chk("restart_addr", 32'(wr_addr), 9);
        go = 1'b0;
        tick();

        // 4a: falling on ch2, ch1 moving the opposite way; equal counts as below
        do_reset();
        tchan = 1'b1; tedge = 1'b1; tlevel = 8'd150; tmode = 1'b1;
        go = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) samp(200, 200);
        samp(100, 200);
        chk("ch1_fall_ignored", 32'(state), 2);
        samp(200, 150);
        chk("ch2_fall_trig", 32'(state), 3);
        chk("ch2_trig_addr", 32'(trig_addr), 9);
        go = 1'b0;
        tick();
        chk("post_abort", 32'(state), 0);

        // 4b: rising test, a sample equal to the level does not trigger
        do_reset();
        tchan = 1'b0; tedge = 1'b0; tlevel = 8'd150;
        go = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) samp(100, 0);
        samp(150, 0);
        samp(150, 0);
        chk("eq_no_rise", 32'(state), 2);
        samp(151, 0);
        chk("rise_above", 32'(state), 3);
        chk("rise_trig_addr", 32'(trig_addr), 10);
        go = 1'b0;
        tick();

        // 6: reset during POST, then sparse samples reproduce scenario 1
        do_reset();
        tlevel = 8'd10;
        go = 1'b1;
        tick();
        for (int v = 0; v < 14; v++) samp(v, 0);
        chk("pre_rst_post", 32'(state), 3);
        smp.sample_en = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_post_state", 32'(state), 0);
        chk("rst_post_addr", 32'(wr_addr), 0);
        chk("rst_post_trig", 32'(trig_addr), 0);
        chk("rst_post_start", 32'(start_addr), 0);
        chk("rst_post_ready", 32'(ready), 0);
        chk("rst_post_wr_en", 32'(wr_en), 0);
        rst = 1'b0;
        smp.sample_en = 1'b0;
        go = 1'b0;
        tick();
        run_ramp(4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
